// File: rtl/arm7_mac_pkg.sv
// Shared definitions for the ARM7 multiply-accumulate unit: op codes,
// FSM state encoding and small op-decode helpers.
package arm7_mac_pkg;

    typedef enum logic [2:0] {
        MAC_MUL   = 3'b000,
        MAC_MLA   = 3'b001,
        MAC_UMULL = 3'b100,
        MAC_UMLAL = 3'b101,
        MAC_SMULL = 3'b110,
        MAC_SMLAL = 3'b111
    } mac_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_ITER = 2'd1,
        FINAL    = 2'd2,
        DONE     = 2'd3
    } mac_state_e;

    // Result is 2*WIDTH wide (xMULL / xMLAL)
    function automatic logic is_long(input logic [2:0] op);
        return op[2];
    endfunction

    // Operands are two's complement (SMULL / SMLAL)
    function automatic logic is_signed(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    // Accumulator is added in (MLA / xMLAL)
    function automatic logic is_acc(input logic [2:0] op);
        return op[0];
    endfunction

    // Codes 010 and 011 are not defined ARM7 multiplies; they run as plain MUL
    // so that the accumulate bit of an undefined code cannot leak into the result.
    function automatic logic [2:0] decode_op(input logic [2:0] op);
        if (op[2:1] == 2'b01) begin
            return MAC_MUL;
        end
        return op;
    endfunction

endpackage

// File: rtl/arm7_mac_unit_digit_step.sv
// One radix-2^BITS_PER_CYCLE step of the shift-add multiplier.
// The new digit product is added into the top half of the partial product and
// the whole thing is shifted right by one digit, so after WIDTH/BITS_PER_CYCLE
// steps the full 2*WIDTH product sits right-aligned in the partial register.
module mac_digit_step #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 8
) (
    input  logic [2*WIDTH-1:0]        i_partial,
    input  logic [WIDTH-1:0]          i_multiplicand,
    input  logic [BITS_PER_CYCLE-1:0] i_digit,
    output logic [2*WIDTH-1:0]        o_next
);

    localparam int PW = WIDTH + BITS_PER_CYCLE;
    localparam int SW = 2*WIDTH + BITS_PER_CYCLE;

    logic [PW-1:0] w_pp;
    logic [SW-1:0] w_sum;

    // Digit product, aligned to the top of the partial product, then shifted down
    always_comb begin
        w_pp   = PW'(i_multiplicand) * PW'(i_digit);
        w_sum  = {{BITS_PER_CYCLE{1'b0}}, i_partial} + {w_pp, {WIDTH{1'b0}}};
        o_next = w_sum[SW-1:BITS_PER_CYCLE];
    end

endmodule

// File: rtl/arm7_mac_unit.sv
// ARM7 multiply-accumulate unit: MUL, MLA, UMULL, UMLAL, SMULL, SMLAL.
// Iterative shift-add on operand magnitudes, sign fix-up and accumulate in a
// single final cycle, result held until the consumer takes it.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | waiting for a request; in_ready high
//   MUL_ITER | retiring BITS_PER_CYCLE multiplier bits per cycle
//   FINAL    | conditional negate, accumulate, register result and flags
//   DONE     | out_valid high, result held until out_ready
module arm7_mac_unit
    import arm7_mac_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rm,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] acc_hi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             flag_n,
    output logic             flag_z,
    output logic             busy
);

    localparam int DW    = 2*WIDTH;
    localparam int ITERS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

    generate
        if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
              BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8) ||
            (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
            $error("arm7_mac_unit: BITS_PER_CYCLE must be 1/2/4/8 and divide WIDTH");
        end
    endgenerate

    mac_state_e          r_state;
    logic                r_long;
    logic                r_neg;
    logic [WIDTH-1:0]    r_mcand;
    logic [WIDTH-1:0]    r_mplier;
    logic [DW-1:0]       r_acc;
    logic [DW-1:0]       r_partial;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;
    logic [WIDTH-1:0]    r_res_lo;
    logic [WIDTH-1:0]    r_res_hi;
    logic                r_flag_n;
    logic                r_flag_z;

    logic [2:0]          w_op_dec;
    logic                w_signed;
    logic                w_neg;
    logic [WIDTH-1:0]    w_rm_mag;
    logic [WIDTH-1:0]    w_rs_mag;
    logic [DW-1:0]       w_acc_in;
    logic [DW-1:0]       w_partial_next;
    logic [DW-1:0]       w_prod;
    logic [DW-1:0]       w_sum;
    logic [WIDTH-1:0]    w_res_lo;
    logic [WIDTH-1:0]    w_res_hi;
    logic                w_flag_n;
    logic                w_flag_z;

    // Request decode: operand magnitudes, result sign and accumulator selection.
    // The most-negative value negates to itself, which read unsigned is its magnitude.
    always_comb begin
        w_op_dec = decode_op(op);
        w_signed = is_signed(w_op_dec);
        w_rm_mag = (w_signed && rm[WIDTH-1]) ? (~rm + WIDTH'(1)) : rm;
        w_rs_mag = (w_signed && rs[WIDTH-1]) ? (~rs + WIDTH'(1)) : rs;
        w_neg    = w_signed && (rm[WIDTH-1] ^ rs[WIDTH-1]);
        w_acc_in = '0;
        if (is_acc(w_op_dec)) begin
            if (is_long(w_op_dec)) begin
                w_acc_in = {acc_hi, acc_lo};
            end else begin
                w_acc_in = {{WIDTH{1'b0}}, acc_lo};
            end
        end
    end

    mac_digit_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_digit_step (
        .i_partial      (r_partial),
        .i_multiplicand (r_mcand),
        .i_digit        (r_mplier[BITS_PER_CYCLE-1:0]),
        .o_next         (w_partial_next)
    );

    // Final-cycle datapath: sign fix-up, accumulate, result width and flags
    always_comb begin
        w_prod = r_neg ? (~r_partial + DW'(1)) : r_partial;
        w_sum  = w_prod + r_acc;
        w_res_lo = w_sum[WIDTH-1:0];
        if (r_long) begin
            w_res_hi = w_sum[DW-1:WIDTH];
            w_flag_n = w_sum[DW-1];
            w_flag_z = (w_sum == '0);
        end else begin
            w_res_hi = '0;
            w_flag_n = w_sum[WIDTH-1];
            w_flag_z = (w_sum[WIDTH-1:0] == '0);
        end
    end

    // Control FSM with operand capture, iteration counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_long      <= 1'b0;
            r_neg       <= 1'b0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_partial   <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_res_lo    <= '0;
            r_res_hi    <= '0;
            r_flag_n    <= 1'b0;
            r_flag_z    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_long     <= is_long(w_op_dec);
                        r_neg      <= w_neg;
                        r_mcand    <= w_rm_mag;
                        r_mplier   <= w_rs_mag;
                        r_acc      <= w_acc_in;
                        r_partial  <= '0;
                        r_cnt      <= CNT_W'(ITERS - 1);
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= MUL_ITER;
                    end
                end
                MUL_ITER: begin
                    r_partial <= w_partial_next;
                    r_mplier  <= r_mplier >> BITS_PER_CYCLE;
                    if (r_cnt == '0) begin
                        r_state <= FINAL;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                FINAL: begin
                    r_res_lo    <= w_res_lo;
                    r_res_hi    <= w_res_hi;
                    r_flag_n    <= w_flag_n;
                    r_flag_z    <= w_flag_z;
                    r_out_valid <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign res_lo    = r_res_lo;
    assign res_hi    = r_res_hi;
    assign flag_n    = r_flag_n;
    assign flag_z    = r_flag_z;

endmodule

// File: tb/tb_arm7_mac_unit.sv
// Directed bench for arm7_mac_unit: three instances (32/8, 32/1, 16/4) run the
// same vector table side by side; multi-cycle corners are hand sequences.
module tb_arm7_mac_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [2:0]  op;
    logic [31:0] rm, rs, acc_lo, acc_hi;
    logic [15:0] rm16, rs16, al16, ah16;

    logic        a_in_ready, a_out_valid, a_n, a_z, a_busy;
    logic [31:0] a_res_lo, a_res_hi;
    logic        b_in_ready, b_out_valid, b_n, b_z, b_busy;
    logic [31:0] b_res_lo, b_res_hi;
    logic        c_in_ready, c_out_valid, c_n, c_z, c_busy;
    logic [15:0] c_res_lo, c_res_hi;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    arm7_mac_unit #(.WIDTH(32), .BITS_PER_CYCLE(8)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .op(op),
        .rm(rm), .rs(rs), .acc_lo(acc_lo), .acc_hi(acc_hi), .out_valid(a_out_valid),
        .out_ready(out_ready), .res_lo(a_res_lo), .res_hi(a_res_hi),
        .flag_n(a_n), .flag_z(a_z), .busy(a_busy));

    arm7_mac_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .op(op),
        .rm(rm), .rs(rs), .acc_lo(acc_lo), .acc_hi(acc_hi), .out_valid(b_out_valid),
        .out_ready(out_ready), .res_lo(b_res_lo), .res_hi(b_res_hi),
        .flag_n(b_n), .flag_z(b_z), .busy(b_busy));

    arm7_mac_unit #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready), .op(op),
        .rm(rm16), .rs(rs16), .acc_lo(al16), .acc_hi(ah16), .out_valid(c_out_valid),
        .out_ready(out_ready), .res_lo(c_res_lo), .res_hi(c_res_hi),
        .flag_n(c_n), .flag_z(c_z), .busy(c_busy));

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rm, rs, al, ah, elo, ehi;
        logic        en, ez;
        logic [15:0] r16, s16, al16, ah16, elo16, ehi16;
        logic        en16, ez16;
    } vec_t;

    localparam int NV = 14;
    vec_t vt[NV];

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_idle_all(input string nm);
        chk({nm, "_a"}, {a_in_ready, a_out_valid, a_busy, a_res_hi, a_res_lo, a_n, a_z},
            {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0});
        chk({nm, "_b"}, {b_in_ready, b_out_valid, b_busy, b_res_hi, b_res_lo, b_n, b_z},
            {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0});
        chk({nm, "_c"}, {c_in_ready, c_out_valid, c_busy, c_res_hi, c_res_lo, c_n, c_z},
            {1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0});
    endtask

    task automatic drive_vec(input int i);
        op     = vt[i].op;
        rm     = vt[i].rm;
        rs     = vt[i].rs;
        acc_lo = vt[i].al;
        acc_hi = vt[i].ah;
        rm16   = vt[i].r16;
        rs16   = vt[i].s16;
        al16   = vt[i].al16;
        ah16   = vt[i].ah16;
    endtask

    task automatic scramble_inputs();
        op     = 3'($urandom);
        rm     = $urandom;
        rs     = $urandom;
        acc_lo = $urandom;
        acc_hi = $urandom;
        rm16   = 16'($urandom);
        rs16   = 16'($urandom);
        al16   = 16'($urandom);
        ah16   = 16'($urandom);
    endtask

    task automatic run_vec(input int i, input bit backpressure);
        int edges, la, lb, lc, ba, bb, bc;
        @(negedge clk);
        drive_vec(i);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        chk($sformatf("v%0d_in_ready", i), {a_in_ready, b_in_ready, c_in_ready}, 3'b111);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble_inputs();
        edges = 0; la = -1; lb = -1; lc = -1;
        ba = a_busy ? 1 : 0;
        bb = b_busy ? 1 : 0;
        bc = c_busy ? 1 : 0;
        for (int k = 0; k < 60 && (la < 0 || lb < 0 || lc < 0); k++) begin
            @(posedge clk);
            #1;
            edges++;
            if (la < 0) begin if (a_out_valid) la = edges; else if (a_busy) ba++; end
            if (lb < 0) begin if (b_out_valid) lb = edges; else if (b_busy) bb++; end
            if (lc < 0) begin if (c_out_valid) lc = edges; else if (c_busy) bc++; end
        end
        chk($sformatf("v%0d_lat_a", i), la, 5);
        chk($sformatf("v%0d_lat_b", i), lb, 33);
        chk($sformatf("v%0d_lat_c", i), lc, 5);
        chk($sformatf("v%0d_busy_a", i), ba, 5);
        chk($sformatf("v%0d_busy_b", i), bb, 33);
        chk($sformatf("v%0d_busy_c", i), bc, 5);
        chk($sformatf("v%0d_res_a", i), {a_res_hi, a_res_lo, a_n, a_z},
            {vt[i].ehi, vt[i].elo, vt[i].en, vt[i].ez});
        chk($sformatf("v%0d_res_b", i), {b_res_hi, b_res_lo, b_n, b_z},
            {vt[i].ehi, vt[i].elo, vt[i].en, vt[i].ez});
        chk($sformatf("v%0d_res_c", i), {c_res_hi, c_res_lo, c_n, c_z},
            {vt[i].ehi16, vt[i].elo16, vt[i].en16, vt[i].ez16});
        if (backpressure) begin
            for (int k = 0; k < 10; k++) begin
                @(posedge clk);
                #1;
                chk($sformatf("v%0d_hold%0d", i, k),
                    {a_out_valid, a_in_ready, a_res_hi, a_res_lo, a_n, a_z},
                    {1'b1, 1'b0, vt[i].ehi, vt[i].elo, vt[i].en, vt[i].ez});
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk($sformatf("v%0d_no_ready_in_done", i), {a_in_ready, b_in_ready, c_in_ready}, 3'b000);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk($sformatf("v%0d_release", i),
            {a_in_ready, a_out_valid, b_in_ready, b_out_valid, c_in_ready, c_out_valid},
            6'b101010);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        //            op      rm            rs            acc_lo        acc_hi        exp_lo        exp_hi        N     Z     rm16     rs16     al16     ah16     elo16    ehi16    N16   Z16
        vt[0]  = '{3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h00000001, 32'hFFFFFFFE, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0,    16'h0,    16'h0001, 16'hFFFE, 1'b1, 1'b0};
        vt[1]  = '{3'b110, 32'h80000000, 32'h80000000, 32'h0,        32'h0,        32'h00000000, 32'h40000000, 1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0,    16'h0,    16'h0000, 16'h4000, 1'b0, 1'b0};
        vt[2]  = '{3'b110, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'h0,    16'h0,    16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
        vt[3]  = '{3'b001, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 16'hFFFF, 16'h0001, 16'h0001, 16'hBEEF, 16'h0000, 16'h0000, 1'b0, 1'b1};
        vt[4]  = '{3'b000, 32'h00010000, 32'h00010000, 32'h00000005, 32'h0,        32'h00000000, 32'h00000000, 1'b0, 1'b1, 16'h0100, 16'h0100, 16'h0005, 16'h0,    16'h0000, 16'h0000, 1'b0, 1'b1};
        vt[5]  = '{3'b111, 32'h00000002, 32'hFFFFFFFD, 32'h00000010, 32'h00000000, 32'h0000000A, 32'h00000000, 1'b0, 1'b0, 16'h0002, 16'hFFFD, 16'h0010, 16'h0000, 16'h000A, 16'h0000, 1'b0, 1'b0};
        vt[6]  = '{3'b101, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
        vt[7]  = '{3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFE, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFE, 1'b1, 1'b0};
        vt[8]  = '{3'b110, 32'h7FFFFFFF, 32'h80000000, 32'h0,        32'h0,        32'h80000000, 32'hC0000000, 1'b1, 1'b0, 16'h7FFF, 16'h8000, 16'h0,    16'h0,    16'h8000, 16'hC000, 1'b1, 1'b0};
        vt[9]  = '{3'b001, 32'h00000003, 32'h00000005, 32'h00000007, 32'h0,        32'h00000016, 32'h00000000, 1'b0, 1'b0, 16'h0003, 16'h0005, 16'h0007, 16'h0,    16'h0016, 16'h0000, 1'b0, 1'b0};
        vt[10] = '{3'b011, 32'h00000003, 32'h00000005, 32'h00000007, 32'h0,        32'h0000000F, 32'h00000000, 1'b0, 1'b0, 16'h0003, 16'h0005, 16'h0007, 16'h0,    16'h000F, 16'h0000, 1'b0, 1'b0};
        vt[11] = '{3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b1};
        vt[12] = '{3'b010, 32'hFFFFFFFF, 32'h00000002, 32'h0,        32'h0,        32'hFFFFFFFE, 32'h00000000, 1'b1, 1'b0, 16'hFFFF, 16'h0002, 16'h0,    16'h0,    16'hFFFE, 16'h0000, 1'b1, 1'b0};
        vt[13] = '{3'b100, 32'h00010000, 32'h00010000, 32'h0,        32'h0,        32'h00000000, 32'h00000001, 1'b0, 1'b0, 16'h0100, 16'h0100, 16'h0,    16'h0,    16'h0000, 16'h0001, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive_vec(0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_idle_all("reset");

        run_vec(0, 1'b1);
        for (int i = 1; i < NV; i++) begin
            run_vec(i, 1'b0);
        end

        // Reset during the third MUL_ITER cycle aborts without a result
        @(negedge clk);
        drive_vec(1);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_busy", {a_busy, b_busy, c_busy}, 3'b111);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_idle_all("mid_reset");
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (a_out_valid || b_out_valid || c_out_valid || a_busy || b_busy || c_busy) seen++;
        end
        chk("aborted_no_result", seen, 0);
        run_vec(8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
